// File: rtl/tsb_pkg.sv
// Shared types and the cyclic find-first helper for the tri-state bus arbiter.
package tsb_pkg;

    // Upper bound on requesters the pick helper can scan.
    localparam int TSB_MAX_REQ = 32;
    localparam int TSB_IDX_W   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DEAD  = 2'd2
    } tsb_state_e;

    typedef struct packed {
        logic                 found;
        logic [TSB_IDX_W-1:0] idx;
    } tsb_pick_t;

    // First set bit of req[n_req-1:0], scanning upward from ptr and wrapping to 0.
    function automatic tsb_pick_t tsb_rr_find(
        input logic [TSB_MAX_REQ-1:0] req,
        input int unsigned            n_req,
        input int unsigned            ptr
    );
        tsb_pick_t            res;
        int unsigned          cand;
        logic [TSB_IDX_W-1:0] sel;
        res = '0;
        for (int unsigned k = 0; k < TSB_MAX_REQ; k++) begin
            cand = ptr + k;
            if (cand >= n_req) begin
                cand = cand - n_req;
            end
            sel = cand[TSB_IDX_W-1:0];
            if ((k < n_req) && !res.found && req[sel]) begin
                res.found = 1'b1;
                res.idx   = sel;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tsb_rr_pick.sv
// Combinational round-robin pick: first requester at or after rr_ptr, cyclically.
module tsb_rr_pick
    import tsb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    output logic [$clog2(N_REQ)-1:0] pick,
    output logic                     found
);

    localparam int IDX_W = $clog2(N_REQ);

    tsb_pick_t res;

    assign res   = tsb_rr_find(TSB_MAX_REQ'(req), N_REQ, 32'(rr_ptr));
    assign pick  = res.idx[IDX_W-1:0];
    assign found = res.found;

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner selection for a shared tri-state net, with break-before-make
// dead cycles between owners and MAX_HOLD preemption when others are waiting.
module tristate_bus_arbiter
    import tsb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DEAD_CYCLES = 2,
    parameter int MAX_HOLD    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         en,
    output logic                     owner_valid,
    output logic [$clog2(N_REQ)-1:0] owner_id,
    output logic                     preempt
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [DEAD_W-1:0] DEAD_MAX = DEAD_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0]  LAST_ID  = IDX_W'(N_REQ - 1);

    tsb_state_e         state_q, state_d;
    logic [N_REQ-1:0]   en_q, en_d;
    logic               valid_q, valid_d;
    logic [IDX_W-1:0]   id_q, id_d;
    logic               preempt_q, preempt_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [DEAD_W-1:0]  dead_cnt_q, dead_cnt_d;

    logic [IDX_W-1:0]   pick;
    logic               found;
    logic               owner_req;
    logic               others_req;
    logic               grant_now;
    logic               to_dead;

    tsb_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .pick   (pick),
        .found  (found)
    );

    // en_q is one-hot for the owner while in GRANT, so it doubles as the owner mask.
    assign owner_req  = |(req & en_q);
    assign others_req = |(req & ~en_q);

    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        valid_d    = valid_q;
        id_d       = id_q;
        preempt_d  = 1'b0;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        dead_cnt_d = dead_cnt_q;
        grant_now  = 1'b0;
        to_dead    = 1'b0;

        unique case (state_q)
            IDLE: begin
                grant_now = found;
            end
            GRANT: begin
                if (!owner_req) begin
                    to_dead = 1'b1;
                end else if ((hold_cnt_q == HOLD_MAX) && others_req) begin
                    to_dead   = 1'b1;
                    preempt_d = 1'b1;
                end else if (hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            DEAD: begin
                if (dead_cnt_q == DEAD_MAX) begin
                    if (found) begin
                        grant_now = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    dead_cnt_d = dead_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = '0;
                valid_d = 1'b0;
            end
        endcase

        if (to_dead) begin
            state_d    = DEAD;
            en_d       = '0;
            valid_d    = 1'b0;
            dead_cnt_d = DEAD_W'(1);
        end

        if (grant_now) begin
            state_d    = GRANT;
            en_d       = N_REQ'(1) << pick;
            valid_d    = 1'b1;
            id_d       = pick;
            hold_cnt_d = HOLD_W'(1);
            rr_ptr_d   = (pick == LAST_ID) ? '0 : pick + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            en_q       <= '0;
            valid_q    <= 1'b0;
            id_q       <= '0;
            preempt_q  <= 1'b0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            dead_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            valid_q    <= valid_d;
            id_q       <= id_d;
            preempt_q  <= preempt_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            dead_cnt_q <= dead_cnt_d;
        end
    end

    assign en          = en_q;
    assign owner_valid = valid_q;
    assign owner_id    = id_q;
    assign preempt     = preempt_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed table plus corner-case sequences for the tri-state bus arbiter,
// with always-on invariant and dead-gap monitors.
module tb_tristate_bus_arbiter;

    localparam int N    = 4;
    localparam int DEAD = 2;
    localparam int HOLD = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] en;
    logic         owner_valid;
    logic [1:0]   owner_id;
    logic         preempt;

    int n_cmp = 0;
    int n_bad = 0;
    int zero_run = 1000;

    typedef struct {
        logic [3:0] req;
        logic [3:0] en;
        logic [1:0] id;
        logic       pre;
    } vec_t;

    vec_t tbl [29];

    tristate_bus_arbiter #(
        .N_REQ       (N),
        .DEAD_CYCLES (DEAD),
        .MAX_HOLD    (HOLD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .en          (en),
        .owner_valid (owner_valid),
        .owner_id    (owner_id),
        .preempt     (preempt)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [3:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] e_en,
                         input logic [1:0] e_id, input logic e_pre);
        logic [7:0] act;
        logic [7:0] exp;
        act = {en, owner_valid, owner_id, preempt};
        exp = {e_en, |e_en, e_id, e_pre};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got en=%b valid=%b id=%0d preempt=%b, required en=%b valid=%b id=%0d preempt=%b",
                     name, en, owner_valid, owner_id, preempt, e_en, |e_en, e_id, e_pre);
        end else begin
            $display("[%0t] %s req=%b en=%b valid=%b id=%0d preempt=%b ok",
                     $time, name, req, en, owner_valid, owner_id, preempt);
        end
    endtask

    // Invariants and minimum undriven gap between any two ownerships.
    always @(negedge clk) begin
        if (!rst_n) begin
            zero_run = 1000;
        end else begin
            n_cmp++;
            if (!$onehot0(en) || (owner_valid !== (|en))) begin
                n_bad++;
                $display("FAIL invariant: en=%b owner_valid=%b, required onehot0 en with owner_valid=|en",
                         en, owner_valid);
            end
            if (en == '0) begin
                zero_run++;
            end else begin
                if (zero_run > 0) begin
                    n_cmp++;
                    if (zero_run < DEAD) begin
                        n_bad++;
                        $display("FAIL dead_gap: %0d idle cycles before en=%b, required >= %0d",
                                 zero_run, en, DEAD);
                    end
                end
                zero_run = 0;
            end
        end
    end

    initial begin
        // Single requester, then simultaneous requests, then wrap-around.
        tbl[0]  = '{4'b0100, 4'b0100, 2'd2, 1'b0};
        tbl[1]  = '{4'b0100, 4'b0100, 2'd2, 1'b0};
        tbl[2]  = '{4'b0100, 4'b0100, 2'd2, 1'b0};
        tbl[3]  = '{4'b0100, 4'b0100, 2'd2, 1'b0};
        tbl[4]  = '{4'b0100, 4'b0100, 2'd2, 1'b0};
        tbl[5]  = '{4'b0000, 4'b0000, 2'd2, 1'b0};
        tbl[6]  = '{4'b0000, 4'b0000, 2'd2, 1'b0};
        tbl[7]  = '{4'b0000, 4'b0000, 2'd2, 1'b0};
        tbl[8]  = '{4'b1010, 4'b1000, 2'd3, 1'b0};
        tbl[9]  = '{4'b1010, 4'b1000, 2'd3, 1'b0};
        tbl[10] = '{4'b0010, 4'b0000, 2'd3, 1'b0};
        tbl[11] = '{4'b0010, 4'b0000, 2'd3, 1'b0};
        tbl[12] = '{4'b0010, 4'b0010, 2'd1, 1'b0};
        tbl[13] = '{4'b0000, 4'b0000, 2'd1, 1'b0};
        tbl[14] = '{4'b0101, 4'b0000, 2'd1, 1'b0};
        tbl[15] = '{4'b0101, 4'b0100, 2'd2, 1'b0};
        tbl[16] = '{4'b1000, 4'b0000, 2'd2, 1'b0};
        tbl[17] = '{4'b1000, 4'b0000, 2'd2, 1'b0};
        tbl[18] = '{4'b1000, 4'b1000, 2'd3, 1'b0};
        tbl[19] = '{4'b1101, 4'b1000, 2'd3, 1'b0};
        tbl[20] = '{4'b0101, 4'b0000, 2'd3, 1'b0};
        tbl[21] = '{4'b0101, 4'b0000, 2'd3, 1'b0};
        tbl[22] = '{4'b0101, 4'b0001, 2'd0, 1'b0};
        tbl[23] = '{4'b0100, 4'b0000, 2'd0, 1'b0};
        tbl[24] = '{4'b0100, 4'b0000, 2'd0, 1'b0};
        tbl[25] = '{4'b0100, 4'b0100, 2'd2, 1'b0};
        tbl[26] = '{4'b0000, 4'b0000, 2'd2, 1'b0};
        tbl[27] = '{4'b0000, 4'b0000, 2'd2, 1'b0};
        tbl[28] = '{4'b0000, 4'b0000, 2'd2, 1'b0};

        #2;
        check("reset", 4'b0000, 2'd0, 1'b0);
        #10;
        rst_n = 1'b1;

        for (int i = 0; i < 29; i++) begin
            step(tbl[i].req);
            check($sformatf("tbl%0d", i), tbl[i].en, tbl[i].id, tbl[i].pre);
        end

        // Preemption: owner 0 holds exactly HOLD cycles while 3 waits.
        step(4'b0001);
        check("pre_grant", 4'b0001, 2'd0, 1'b0);
        for (int k = 2; k <= HOLD; k++) begin
            step(4'b1001);
            check($sformatf("pre_hold%0d", k), 4'b0001, 2'd0, 1'b0);
        end
        step(4'b1001);
        check("pre_drop", 4'b0000, 2'd0, 1'b1);
        step(4'b1001);
        check("pre_dead2", 4'b0000, 2'd0, 1'b0);
        step(4'b1001);
        check("pre_next", 4'b1000, 2'd3, 1'b0);

        // Lone owner saturates and keeps the bus; late competitor preempts at once.
        for (int k = 0; k < 12; k++) begin
            step(4'b1000);
            check($sformatf("sat%0d", k), 4'b1000, 2'd3, 1'b0);
        end
        step(4'b1001);
        check("sat_drop", 4'b0000, 2'd3, 1'b1);
        step(4'b1001);
        check("sat_dead2", 4'b0000, 2'd3, 1'b0);
        step(4'b1001);
        check("sat_next", 4'b0001, 2'd0, 1'b0);

        // Release on the expiry cycle counts as a release.
        for (int k = 2; k <= HOLD; k++) begin
            step(4'b0011);
            check($sformatf("rel_hold%0d", k), 4'b0001, 2'd0, 1'b0);
        end
        step(4'b0010);
        check("rel_drop", 4'b0000, 2'd0, 1'b0);
        step(4'b0010);
        check("rel_dead2", 4'b0000, 2'd0, 1'b0);
        step(4'b0010);
        check("rel_next", 4'b0010, 2'd1, 1'b0);

        // Asynchronous reset while owner 1 drives; rr_ptr must restart at 0.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 4'b0000, 2'd0, 1'b0);
        req = 4'b0000;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        step(4'b1010);
        check("rst_rr", 4'b0010, 2'd1, 1'b0);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                req = 4'($urandom_range(0, 15));
            end
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
